spi_tx_feeder: RTL and testbench
================================

# spi_tx_feeder

Word-buffering feeder between the system logic and the master-mode SPI engine. Accepts words through a valid/ready write port into a small FIFO, then drives the engine's `process_next_word` / `processing_word` handshake and `data_word_send` bus one word at a time. It replaces the ad-hoc counter logic in the top level, so any producer can queue transmit words without tracking engine state.

## Interface
Parameters:
- `WORD_LEN`, 8, width of a transmit word; must match the SPI engine's word length.
- `DEPTH_LOG2`, 3, FIFO depth is 2^DEPTH_LOG2 words (default 8).
- `FILL_WORD`, 0, word sent when the FIFO is empty; used only with `SPI_FEEDER_IDLE_FILL_EN`.

Ports:
- `master_clock`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `wr_data`  in  WORD_LEN  word to queue.
- `wr_valid`  in  1  write strobe; one word per cycle.
- `wr_ready`  out  1  high when FIFO not full (registered count < 2^DEPTH_LOG2).
- `spi_is_ready`  in  1  SPI engine `is_ready`; feeder issues no request while low.
- `processing_word`  in  1  SPI engine busy flag.
- `process_next_word`  out  1  request to the engine to start a word.
- `data_word_send`  out  WORD_LEN  word presented to the engine.
- `fifo_count`  out  DEPTH_LOG2+1  words currently queued.
- `overflow`  out  1  sticky; set when a write is dropped.

## Operation
- The FIFO is a circular buffer with DEPTH_LOG2-bit read and write pointers that wrap modulo depth, plus a DEPTH_LOG2+1-bit count.
- Write is accepted when `wr_valid && wr_ready`. If `wr_valid` is high while full, the word is dropped, `overflow` is set, and the count does not change. `wr_ready` is computed from the registered count, so a same-cycle pop does not make room.
- Pop and write in the same cycle: count unchanged, both pointers advance.
- FSM states:
  - IDLE: `process_next_word`=0. If `spi_is_ready && !processing_word && fifo_count>0`, pop the head into `data_word_send` and go to REQ.
  - REQ: `process_next_word`=1 and `data_word_send` held stable. On `processing_word`=1, go to BUSY.
  - BUSY: `process_next_word`=0. On `processing_word`=0, go to IDLE.
- `spi_is_ready` low in REQ or BUSY: go to IDLE, `process_next_word`=0, and the popped word is discarded (not re-queued).
- `data_word_send` holds its last value outside REQ.

## Timing
- Reset values:
  - `process_next_word`=0, `data_word_send`=0, `wr_ready`=1, `fifo_count`=0, `overflow`=0.
  - FSM in IDLE, both pointers 0.
- Latency: write accepted at edge N → `fifo_count` updates after edge N → pop at edge N+1 → `process_next_word`=1 and new `data_word_send` visible after edge N+1.
- `process_next_word` falls on the edge after `processing_word` is sampled high.
- Minimum spacing between words: back-to-back words need IDLE→REQ after BUSY, which inserts 1 idle cycle after `processing_word` falls.
- Asynchronous `resetn` assertion forces all reset values immediately, including mid-word. Deassertion is synchronised externally.

## Configuration
- `SPI_FEEDER_IDLE_FILL_EN` defined:
  - In IDLE with the FIFO empty and the engine ready, the feeder enters REQ with `data_word_send`=FILL_WORD and does not pop.
  - The link transmits continuously; `fifo_count` is unaffected.
- Undefined: the feeder stays in IDLE while the FIFO is empty; no fill words are ever sent.

## Test plan
- **Reset:** hold `resetn`=0, then release → all outputs at reset values; `wr_ready`=1.
- **Single word:** write 0x9E, with `processing_word` model rising 2 cycles after the request → `process_next_word` high exactly 1 cycle after the write is accepted, `data_word_send`=0x9E, request drops 1 cycle after `processing_word`=1.
- **Fill and overflow:** 9 back-to-back writes 0x01..0x09 with `spi_is_ready`=0 → `fifo_count`=8, `wr_ready`=0, `overflow`=1. After enabling the engine, words are sent in order 0x01..0x08; 0x09 is never sent.
- **Wrap-around:** 20 words streamed through depth-8 FIFO with concurrent write/pop → output order exact and `fifo_count` never exceeds 8.
- **Engine reset mid-word:** drop `spi_is_ready` during BUSY → FSM in IDLE, `process_next_word`=0, that word lost, next queued word sent after `spi_is_ready` returns.
- **Idle fill:** with the FIFO empty, engine ready, `FILL_WORD`=0x00 →
  - with `SPI_FEEDER_IDLE_FILL_EN`: repeated requests carrying 0x00;
  - without it: `process_next_word` stays 0.

Source files
------------

// File: rtl/spi_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_tx_feeder : word FIFO feeding the master SPI engine's word handshake     |
// | Optional: SPI_FEEDER_IDLE_FILL_EN sends FILL_WORD whenever the FIFO is empty |
// | Revision 1.0 : initial release                                               |
// +----------------------------------------------------------------------------+
module spi_tx_feeder #(
    parameter int unsigned         WORD_LEN   = 8,
    parameter int unsigned         DEPTH_LOG2 = 3,
    parameter logic [WORD_LEN-1:0] FILL_WORD  = '0
) (
    input  logic                  master_clock,
    input  logic                  resetn,
    input  logic [WORD_LEN-1:0]   wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  spi_is_ready,
    input  logic                  processing_word,
    output logic                  process_next_word,
    output logic [WORD_LEN-1:0]   data_word_send,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);

    localparam int unsigned         c_DEPTH_N = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL    = c_DEPTH_N[DEPTH_LOG2:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t                r_state;
    logic [WORD_LEN-1:0]   r_mem [c_DEPTH_N];
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  r_req;
    logic [WORD_LEN-1:0]   r_data;

    logic w_push;
    logic w_pop;
    logic w_engine_free;

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never frees a slot for a write.
    assign wr_ready      = (r_count < c_FULL);
    assign w_push        = wr_valid && wr_ready;
    assign w_engine_free = (r_state == S_IDLE) && spi_is_ready && !processing_word;
    assign w_pop         = w_engine_free && (r_count != '0);

    assign process_next_word = r_req;
    assign data_word_send    = r_data;
    assign fifo_count        = r_count;
    assign overflow          = r_overflow;

    always_ff @(posedge master_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2)'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (wr_valid && !wr_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req <= 1'b0;
                    if (w_pop) begin
                        r_data  <= r_mem[r_rd_ptr];
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
`ifdef SPI_FEEDER_IDLE_FILL_EN
                    else if (w_engine_free) begin
                        r_data  <= FILL_WORD;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
`endif
                end
                S_REQ: begin
                    // An engine that drops ready abandons the popped word.
                    if (!spi_is_ready) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (processing_word) begin
                        r_req   <= 1'b0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_req <= 1'b0;
                    if (!spi_is_ready || !processing_word) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for spi_tx_feeder with a small SPI engine handshake model.
module tb_spi_tx_feeder;

    logic       master_clock = 1'b0;
    logic       resetn;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       spi_is_ready;
    logic       processing_word;
    logic       process_next_word;
    logic [7:0] data_word_send;
    logic [3:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    int fill_cnt = 0;
    int m_st     = 0;
    int m_dly    = 0;

    always #5 master_clock = ~master_clock;

    spi_tx_feeder #(
        .WORD_LEN   (8),
        .DEPTH_LOG2 (3),
        .FILL_WORD  (8'h00)
    ) dut (
        .master_clock      (master_clock),
        .resetn            (resetn),
        .wr_data           (wr_data),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .spi_is_ready      (spi_is_ready),
        .processing_word   (processing_word),
        .process_next_word (process_next_word),
        .data_word_send    (data_word_send),
        .fifo_count        (fifo_count),
        .overflow          (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge master_clock);
        #2;
    endtask

    // Engine model: latch the word on a new request, raise busy two cycles
    // later, hold it for three cycles, then drop it.
    initial begin
        processing_word = 1'b0;
        forever begin
            @(posedge master_clock);
            #1;
            if (!resetn || !spi_is_ready) begin
                processing_word = 1'b0;
                m_st = 0;
            end else begin
                case (m_st)
                    0: if (process_next_word) begin
                        if (data_word_send != 8'h00) rx_q.push_back(data_word_send);
                        else fill_cnt++;
                        m_dly = 1;
                        m_st  = 1;
                    end
                    1: if (m_dly == 0) begin
                        processing_word = 1'b1;
                        m_dly = 2;
                        m_st  = 2;
                    end else m_dly--;
                    default: if (m_dly == 0) begin
                        processing_word = 1'b0;
                        m_st = 0;
                    end else m_dly--;
                endcase
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        int sent;
        int maxc;
        int mism;
        int waited;

        resetn       = 1'b0;
        wr_data      = 8'h00;
        wr_valid     = 1'b0;
        spi_is_ready = 1'b0;
        repeat (3) tick();
        check_val("rst_req",   process_next_word, 0);
        check_val("rst_data",  data_word_send,    8'h00);
        check_val("rst_ready", wr_ready,          1);
        check_val("rst_count", fifo_count,        0);
        check_val("rst_ovf",   overflow,          0);
        resetn = 1'b1;
        tick();
        check_val("post_rst_ready", wr_ready,   1);
        check_val("post_rst_count", fifo_count, 0);

        // Idle behaviour with an empty FIFO and a ready engine
        spi_is_ready = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (process_next_word) hi_cnt++;
        end
`ifdef SPI_FEEDER_IDLE_FILL_EN
        check_val("fill_seen",  (fill_cnt >= 2), 1);
        check_val("fill_count", fifo_count,      0);
        spi_is_ready = 1'b0;
        repeat (3) tick();
`else
        check_val("idle_no_req",  hi_cnt,         0);
        check_val("idle_data",    data_word_send, 8'h00);
        check_val("idle_no_fill", fill_cnt,       0);

        // Single word with exact handshake timing
        wr_data  = 8'h9E;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check_val("sw_count_n",  fifo_count,        1);
        check_val("sw_req_n",    process_next_word, 0);
        tick();
        check_val("sw_req_n1",   process_next_word, 1);
        check_val("sw_data_n1",  data_word_send,    8'h9E);
        check_val("sw_count_n1", fifo_count,        0);
        tick();
        check_val("sw_req_n2",   process_next_word, 1);
        tick();
        check_val("sw_busy_n3",  processing_word,   1);
        check_val("sw_req_n3",   process_next_word, 1);
        tick();
        check_val("sw_req_drop", process_next_word, 0);
        repeat (10) tick();
        check_val("sw_rx_size",  rx_q.size(),       1);
        if (rx_q.size() > 0) check_val("sw_rx_word", rx_q[0], 8'h9E);
        check_val("sw_data_hold", data_word_send,   8'h9E);
        spi_is_ready = 1'b0;
        tick();
`endif

        // Fill to capacity and overflow with the engine held off
        rx_q.delete();
        for (int i = 1; i <= 9; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        check_val("ovf_count", fifo_count, 8);
        check_val("ovf_ready", wr_ready,   0);
        check_val("ovf_flag",  overflow,   1);
        spi_is_ready = 1'b1;
        waited = 0;
        while (rx_q.size() < 8 && waited < 300) begin
            tick();
            waited++;
        end
        check_val("ovf_drain_timeout", (waited >= 300), 0);
        repeat (30) tick();
        check_val("ovf_rx_size", rx_q.size(), 8);
        for (int i = 0; i < 8 && i < rx_q.size(); i++)
            check_val($sformatf("ovf_rx%0d", i), rx_q[i], 32'(i + 1));
        check_val("ovf_count_end", fifo_count, 0);
        check_val("ovf_sticky",    overflow,   1);

        // Wrap-around streaming with concurrent write and pop
        rx_q.delete();
        sent = 0;
        maxc = 0;
        waited = 0;
        while (rx_q.size() < 20 && waited < 600) begin
            if (sent < 20 && wr_ready) begin
                wr_data  = 8'(8'h40 + sent);
                wr_valid = 1'b1;
                sent++;
            end else begin
                wr_valid = 1'b0;
            end
            tick();
            waited++;
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        wr_valid = 1'b0;
        check_val("wrap_timeout", (waited >= 600), 0);
        check_val("wrap_rx_size", rx_q.size(),     20);
        mism = 0;
        for (int i = 0; i < rx_q.size(); i++)
            if (rx_q[i] != 8'(8'h40 + i)) mism++;
        check_val("wrap_order", mism, 0);
        check_val("wrap_max",   maxc, 8);

        // Engine drops ready while busy: word abandoned, next word follows
        repeat (10) tick();
        spi_is_ready = 1'b0;
        tick();
        rx_q.delete();
        wr_data = 8'hA1; wr_valid = 1'b1; tick();
        wr_data = 8'hA2; tick();
        wr_valid = 1'b0;
        spi_is_ready = 1'b1;
        waited = 0;
        while (!(processing_word && !process_next_word) && waited < 50) begin
            tick();
            waited++;
        end
        check_val("er_busy_timeout", (waited >= 50), 0);
        spi_is_ready = 1'b0;
        tick();
        check_val("er_req",   process_next_word, 0);
        check_val("er_count", fifo_count,        1);
        repeat (5) tick();
        check_val("er_req_hold",   process_next_word, 0);
        check_val("er_count_hold", fifo_count,        1);
        spi_is_ready = 1'b1;
        waited = 0;
        while (rx_q.size() < 2 && waited < 100) begin
            tick();
            waited++;
        end
        check_val("er_rx_size", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check_val("er_rx0", rx_q[0], 8'hA1);
            check_val("er_rx1", rx_q[1], 8'hA2);
        end
        check_val("er_count_end", fifo_count, 0);

        // Asynchronous reset in the middle of a request
        repeat (10) tick();
        spi_is_ready = 1'b0;
        tick();
        wr_data = 8'hB1; wr_valid = 1'b1; tick();
        wr_data = 8'hB2; tick();
        wr_data = 8'hB3; tick();
        wr_valid = 1'b0;
        spi_is_ready = 1'b1;
        waited = 0;
        while (!process_next_word && waited < 20) begin
            tick();
            waited++;
        end
        check_val("ar_req_timeout", (waited >= 20), 0);
        #3;
        resetn = 1'b0;
        #1;
        check_val("ar_req",   process_next_word, 0);
        check_val("ar_data",  data_word_send,    8'h00);
        check_val("ar_count", fifo_count,        0);
        check_val("ar_ready", wr_ready,          1);
        check_val("ar_ovf",   overflow,          0);
        tick();
        resetn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
